// File: rtl/div_seq_pkg.sv
// Shared types and defaults for the divider job sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package div_seq_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      ISSUE = 2'b01,
      WAIT  = 2'b10,
      HOLD  = 2'b11
   } seq_state_t;

   typedef enum logic [1:0] {
      ERR_OK      = 2'b00,
      ERR_DIV0    = 2'b01,
      ERR_TIMEOUT = 2'b10
   } div_err_t;

   localparam int DEFAULT_WIDTH = 32;

   // Divider needs about 2*WIDTH cycles; the extra 8 is slack before declaring it hung.
   function automatic int default_timeout(input int width);
      return 2 * width + 8;
   endfunction

endpackage

// File: rtl/div_job_fifo.sv
// Synchronous job FIFO holding {tag, den, num} words.
// Latency: a pushed word is visible at dout the cycle after the push.
// Backpressure: push ignored when full, pop ignored when empty; full comes from the registered count only.
// Ports: CLK/RSTa clock and async active-low reset; push/din write side; pop/dout read side;
//        full/empty/count occupancy status.
module div_job_fifo
   import div_seq_pkg::*;
#(
   parameter int DW    = 8,
   parameter int DEPTH = 4
) (
   input  logic                       CLK,
   input  logic                       RSTa,
   input  logic                       push,
   input  logic [DW-1:0]              din,
   input  logic                       pop,
   output logic [DW-1:0]              dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [DW-1:0] mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   // Storage carries no reset; only the pointers and count define validity.
   always_ff @(posedge CLK) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   // DEPTH is a power of two, so the pointers wrap naturally.
   always_ff @(posedge CLK or negedge RSTa) begin
      if (!RSTa) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/div_job_sequencer.sv
// Feeds queued divide jobs to the multi-cycle divider one at a time and returns tagged results.
// Latency: push into an empty idle block -> pop next cycle -> div_start the cycle after; out_valid the cycle after div_done.
// Backpressure: in_ready = FIFO not full; a result is held on the output until out_ready, and no new job issues meanwhile.
// Ports: CLK/RSTa; in_* job input (valid/ready); div_* divider interface; out_* result output (valid/ready); busy.
module div_job_sequencer
   import div_seq_pkg::*;
#(
   parameter int WIDTH   = DEFAULT_WIDTH,
   parameter int DEPTH   = 4,
   parameter int TAG_W   = 4,
   parameter int TIMEOUT = default_timeout(WIDTH)
) (
   input  logic             CLK,
   input  logic             RSTa,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_num,
   input  logic [WIDTH-1:0] in_den,
   input  logic [TAG_W-1:0] in_tag,
   output logic             div_start,
   output logic [WIDTH-1:0] div_num,
   output logic [WIDTH-1:0] div_den,
   input  logic [WIDTH-1:0] div_coc,
   input  logic [WIDTH-1:0] div_res,
   input  logic             div_done,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_coc,
   output logic [WIDTH-1:0] out_res,
   output logic [TAG_W-1:0] out_tag,
   output logic [1:0]       out_err,
   output logic             busy
);

   localparam int FW = TAG_W + 2 * WIDTH;
   localparam int TW = $clog2(TIMEOUT + 1);

   seq_state_t             state;
   logic [WIDTH-1:0]       op_num;
   logic [WIDTH-1:0]       op_den;
   logic [TAG_W-1:0]       op_tag;
   logic [TW-1:0]          timer;

   logic [FW-1:0]          fifo_dout;
   logic                   fifo_full;
   logic                   fifo_empty;
   logic [$clog2(DEPTH):0] fifo_count;
   logic                   fifo_push;
   logic                   fifo_pop;
   logic [WIDTH-1:0]       head_num;
   logic [WIDTH-1:0]       head_den;
   logic [TAG_W-1:0]       head_tag;

   assign fifo_push = in_valid && !fifo_full;
   assign fifo_pop  = (state == IDLE) && !fifo_empty;
   assign in_ready  = !fifo_full;
   assign head_num  = fifo_dout[WIDTH-1:0];
   assign head_den  = fifo_dout[2*WIDTH-1:WIDTH];
   assign head_tag  = fifo_dout[FW-1:2*WIDTH];
   assign div_num   = op_num;
   assign div_den   = op_den;
   assign busy      = (state != IDLE) || (fifo_count != '0);

   div_job_fifo #(
      .DW    (FW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .CLK   (CLK),
      .RSTa  (RSTa),
      .push  (fifo_push),
      .din   ({in_tag, in_den, in_num}),
      .pop   (fifo_pop),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_ff @(posedge CLK or negedge RSTa) begin
      if (!RSTa) begin
         state     <= IDLE;
         op_num    <= '0;
         op_den    <= '0;
         op_tag    <= '0;
         timer     <= '0;
         div_start <= 1'b0;
         out_valid <= 1'b0;
         out_coc   <= '0;
         out_res   <= '0;
         out_tag   <= '0;
         out_err   <= ERR_OK;
      end else begin
         div_start <= 1'b0;
         case (state)
            IDLE: begin
               if (!fifo_empty) begin
                  op_num <= head_num;
                  op_den <= head_den;
                  op_tag <= head_tag;
                  // Zero divisor never reaches the divider; answer it locally.
                  if (head_den == '0) begin
                     out_valid <= 1'b1;
                     out_coc   <= '1;
                     out_res   <= head_num;
                     out_tag   <= head_tag;
                     out_err   <= ERR_DIV0;
                     state     <= HOLD;
                  end else begin
                     // Registered start, so it is high exactly while in ISSUE.
                     div_start <= 1'b1;
                     state     <= ISSUE;
                  end
               end
            end
            ISSUE: begin
               timer <= '0;
               state <= WAIT;
            end
            WAIT: begin
               timer <= timer + TW'(1);
               // Done is checked first so it wins over a coincident timeout.
               if (div_done) begin
                  out_valid <= 1'b1;
                  out_coc   <= div_coc;
                  out_res   <= div_res;
                  out_tag   <= op_tag;
                  out_err   <= ERR_OK;
                  state     <= HOLD;
               end else if (timer == TW'(TIMEOUT - 1)) begin
                  out_valid <= 1'b1;
                  out_coc   <= '0;
                  out_res   <= '0;
                  out_tag   <= op_tag;
                  out_err   <= ERR_TIMEOUT;
                  state     <= HOLD;
               end
            end
            HOLD: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
